// File: rtl/lab3_converter_seq_if.sv
// Word-level handshake bundle between a producer/consumer and the Excess-3 sequencer.
// The slave side is the sequencer; the master side feeds words and takes results.
interface lab3_converter_seq_if #(parameter int NDIG = 1);
  logic                In_Valid;
  logic                In_Ready;
  logic [4*NDIG-1:0]   In_Data;
  logic                Out_Valid;
  logic                Out_Ready;
  logic [4*NDIG-1:0]   Out_Data;
  logic [NDIG-1:0]     Out_Err;

  modport slave  (input  In_Valid, In_Data, Out_Ready,
                  output In_Ready, Out_Valid, Out_Data, Out_Err);
  modport master (output In_Valid, In_Data, Out_Ready,
                  input  In_Ready, Out_Valid, Out_Data, Out_Err);
endinterface

// File: rtl/lab3_converter_seq.sv
// Serialises NDIG Excess-3 digits LSB-first into an external serial converter and
// reassembles its Z stream into a parallel BCD word, flagging out-of-range digits.
module lab3_converter_seq #(parameter int NDIG = 1) (
  input  logic                 Clk,
  input  logic                 Rst,
  lab3_converter_seq_if.slave  bus,
  output logic                 Cv_X,
  output logic                 Cv_Rst,
  input  logic                 Cv_Z
);
  localparam int         W        = 4*NDIG;
  localparam logic [2:0] LAST_DIG = 3'(NDIG-1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_sh, w_sh_next, r_res;
  logic [NDIG-1:0] r_err, w_err;
  logic [1:0]      r_bit;
  logic [2:0]      r_dig;
  logic            r_cvx, r_cvrst;
  logic            w_accept, w_shift;

  assign w_accept = bus.In_Valid && (r_state == IDLE);
  assign w_shift  = (r_state == SHIFT);

  for (genvar i = 0; i < NDIG; i++) begin : g_err
    assign w_err[i] = (bus.In_Data[4*i +: 4] < 4'd3) || (bus.In_Data[4*i +: 4] > 4'd12);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SHIFT;
      SHIFT:   if (r_bit == 2'd3) w_next = (r_dig == LAST_DIG) ? DONE : GAP;
      GAP:     w_next = SHIFT;
      DONE:    if (bus.Out_Ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The digit being sent always sits at r_sh[0]; GAP holds the register still.
  always_comb begin
    w_sh_next = r_sh;
    if (w_accept)     w_sh_next = bus.In_Data;
    else if (w_shift) w_sh_next = r_sh >> 1;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_res   <= '0;
      r_err   <= '0;
      r_bit   <= '0;
      r_dig   <= '0;
      r_cvx   <= 1'b0;
      r_cvrst <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sh    <= w_sh_next;
      if (w_accept) begin
        r_err <= w_err;
        r_bit <= '0;
        r_dig <= '0;
      end
      // Z arrives LSB-first; after 4*NDIG captures digit 0 bit 0 lands at r_res[0].
      if (w_shift) begin
        r_res <= {Cv_Z, r_res[W-1:1]};
        r_bit <= r_bit + 2'd1;
        if (r_bit == 2'd3 && r_dig != LAST_DIG) r_dig <= r_dig + 3'd1;
      end
      // Converter pins come straight from flops so they cannot glitch.
      r_cvrst <= (w_next == SHIFT);
      r_cvx   <= (w_next == SHIFT) && w_sh_next[0];
    end
  end

  assign bus.In_Ready  = (r_state == IDLE);
  assign bus.Out_Valid = (r_state == DONE);
  assign bus.Out_Data  = r_res;
  assign bus.Out_Err   = r_err;
  assign Cv_X          = r_cvx;
  assign Cv_Rst        = r_cvrst;
endmodule

// File: tb/tb_lab3_converter_seq.sv
// Drives an NDIG=1 and an NDIG=2 sequencer, each wired to a behavioural serial
// Excess-3 -> BCD converter; a per-instance scoreboard checks every output word.
module tb_lab3_converter_seq;
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge Clk) cyc++;

  logic       iv[2];
  logic [7:0] id[2];
  logic       ordy[2];
  logic       ir[2], ov[2], cvx[2], cvr[2], cvz[2];
  logic [7:0] od[2];
  logic [1:0] oe[2];
  int         pending[2];

  lab3_converter_seq_if #(.NDIG(1)) b1();
  lab3_converter_seq_if #(.NDIG(2)) b2();

  lab3_converter_seq #(.NDIG(1)) dut1 (.Clk(Clk), .Rst(Rst), .bus(b1),
    .Cv_X(cvx[0]), .Cv_Rst(cvr[0]), .Cv_Z(cvz[0]));
  lab3_converter_seq #(.NDIG(2)) dut2 (.Clk(Clk), .Rst(Rst), .bus(b2),
    .Cv_X(cvx[1]), .Cv_Rst(cvr[1]), .Cv_Z(cvz[1]));

  assign b1.In_Valid  = iv[0];
  assign b1.In_Data   = id[0][3:0];
  assign b1.Out_Ready = ordy[0];
  assign b2.In_Valid  = iv[1];
  assign b2.In_Data   = id[1];
  assign b2.Out_Ready = ordy[1];
  assign ir[0] = b1.In_Ready;
  assign ir[1] = b2.In_Ready;
  assign ov[0] = b1.Out_Valid;
  assign ov[1] = b2.Out_Valid;
  assign od[0] = {4'h0, b1.Out_Data};
  assign od[1] = b2.Out_Data;
  assign oe[0] = {1'b0, b1.Out_Err};
  assign oe[1] = b2.Out_Err;

  typedef struct {
    logic [7:0] d;
    logic [1:0] e;
    int         acc;
  } sb_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_bcd(input logic [7:0] d, input int n);
    logic [7:0] r = '0;
    for (int k = 0; k < n; k++) r[4*k +: 4] = d[4*k +: 4] - 4'd3;
    return r;
  endfunction

  function automatic logic [1:0] exp_err(input logic [7:0] d, input int n);
    logic [1:0] r = '0;
    for (int k = 0; k < n; k++) r[k] = (d[4*k +: 4] < 4'd3) || (d[4*k +: 4] > 4'd12);
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int N   = g + 1;
    localparam int LAT = 5*N - 1;
    logic [1:0] bp;
    logic       bw, s;
    sb_t        q[$];
    int         lows;
    bit         seenh, infl, ovp;

    // Serial subtractor of 3 (0011) LSB-first, reset by the sequencer's Cv_Rst.
    assign s      = ~bp[1];
    assign cvz[g] = cvx[g] ^ s ^ bw;
    always @(posedge Clk or negedge cvr[g]) begin
      if (!cvr[g]) begin
        bp <= 2'd0;
        bw <= 1'b0;
      end else begin
        bp <= bp + 2'd1;
        bw <= (~cvx[g] & (s | bw)) | (s & bw);
      end
    end

    always @(negedge Clk) begin
      if (!Rst) begin
        q.delete();
        pending[g] = 0;
        infl = 0;
        ovp  = 0;
      end else begin
        if (ov[g] && !ovp) begin
          chk($sformatf("u%0d_out_expected", g), 32'(q.size() != 0), 1);
          if (q.size() != 0) chk($sformatf("u%0d_latency", g), cyc, q[0].acc + LAT);
          chk($sformatf("u%0d_gap_edges", g), lows, N - 1);
          infl = 0;
        end
        if (ov[g] && ordy[g]) begin
          chk($sformatf("u%0d_handshake_expected", g), 32'(q.size() != 0), 1);
          if (q.size() != 0) begin
            sb_t        e;
            logic [7:0] m;
            e = q.pop_front();
            m = '0;
            for (int k = 0; k < N; k++) if (!e.e[k]) m[4*k +: 4] = 4'hF;
            chk($sformatf("u%0d_data", g), od[g] & m, e.d & m);
            chk($sformatf("u%0d_err", g), oe[g], e.e);
            pending[g]--;
          end
        end
        if (infl && !ov[g]) begin
          if (cvr[g]) seenh = 1;
          else if (seenh) lows++;
        end
        if (iv[g] && ir[g]) begin
          q.push_back('{d: exp_bcd(id[g], N), e: exp_err(id[g], N), acc: cyc + 1});
          pending[g]++;
          infl  = 1;
          lows  = 0;
          seenh = 0;
        end
        ovp = ov[g];
      end
    end
  end

  task automatic send(input int i, input logic [7:0] d);
    int n = 0;
    iv[i] = 1'b1;
    id[i] = d;
    while (!ir[i] && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk($sformatf("u%0d_send_wait", i), 32'(n < 50), 1);
    @(posedge Clk); #1;
    iv[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int n = 0;
    while ((pending[i] != 0 || ov[i]) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk($sformatf("u%0d_drain_wait", i), 32'(n < 200), 1);
    @(posedge Clk); #1;
  endtask

  initial begin
    int seen;
    int n;
    Rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; id[i] = '0; ordy[i] = 1'b1;
    end
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_rst_ov", i), ov[i], 0);
      chk($sformatf("u%0d_rst_ir", i), ir[i], 1);
      chk($sformatf("u%0d_rst_cvr", i), cvr[i], 0);
      chk($sformatf("u%0d_rst_cvx", i), cvx[i], 0);
      chk($sformatf("u%0d_rst_od", i), od[i], 0);
      chk($sformatf("u%0d_rst_oe", i), oe[i], 0);
    end
    @(posedge Clk); #1;
    Rst = 1'b1;

    for (int d = 3; d <= 12; d++) begin
      send(0, 8'(d));
      drain(0);
    end
    send(0, 8'h0F); drain(0);
    send(0, 8'h00); drain(0);

    send(1, 8'hC4); drain(1);
    send(1, 8'h39); drain(1);
    send(1, 8'h1D); drain(1);

    // Back-pressure in DONE, then a word queued to land right after the release.
    ordy[0] = 1'b0;
    send(0, 8'h08);
    n = 0;
    while (!ov[0] && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("bp_reach_done", ov[0], 1);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge Clk);
      chk("bp_od", od[0], 8'h05);
      chk("bp_oe", oe[0], 0);
      chk("bp_ir", ir[0], 0);
      chk("bp_cvr", cvr[0], 0);
    end
    @(posedge Clk); #1;
    ordy[0] = 1'b1;
    iv[0]   = 1'b1;
    id[0]   = 8'h09;
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("bp_released_ov", ov[0], 0);
    chk("bp_released_ir", ir[0], 1);
    @(posedge Clk); #1;
    iv[0] = 1'b0;
    chk("bp_next_accepted", ir[0], 0);
    drain(0);

    // Reset during the third bit discards the word in flight.
    send(0, 8'h05);
    @(posedge Clk);
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    chk("midrst_ov", ov[0], 0);
    chk("midrst_cvr", cvr[0], 0);
    chk("midrst_cvx", cvx[0], 0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge Clk);
      seen += int'(ov[0]);
    end
    chk("midrst_no_out", seen, 0);
    send(0, 8'h07); drain(0);

    // In_Valid stays high while In_Data churns; only the first word is taken.
    iv[0] = 1'b1;
    id[0] = 8'h0A;
    @(posedge Clk); #1;
    for (int k = 0; k < 4; k++) begin
      chk("busy_ir", ir[0], 0);
      id[0] = 8'(4 + k);
      if (k != 3) begin
        @(posedge Clk); #1;
      end
    end
    iv[0] = 1'b0;
    drain(0);
    chk("busy_ir_idle", ir[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
